// File: rtl/axi_burst_splitter_pkg.sv
// rtl/axi_burst_splitter_pkg.sv - shared AXI constants, helpers and splitter state encoding
package axi_burst_splitter_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         AXI_4K         = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    function automatic int calculate_AXI_OFFSET_W(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic [2:0] calculate_AXI_AXSIZE(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// rtl/axi_burst_calc.sv - combinational size of the next burst from address and bytes remaining
module axi_burst_calc
    import axi_burst_splitter_pkg::*;
#(
    parameter int AXI_DATA_W      = 32,
    parameter int LEN_W           = 20,
    parameter int MAX_BURST_BEATS = 256,
    parameter int OFFSET_W        = 2
) (
    input  logic [11:0]         addr_lo_i,
    input  logic [LEN_W-1:0]    remaining_i,
    output logic [12:0]         bytes_o,
    output logic [7:0]          beats_m1_o,
    output logic [OFFSET_W-1:0] off_o,
    output logic                last_o
);
    localparam int CW       = ((LEN_W > 13) ? LEN_W : 13) + 1;
    localparam int BYTES    = AXI_DATA_W / 8;
    localparam int SHIFT    = calculate_AXI_OFFSET_W(AXI_DATA_W);
    localparam int MAXB_RAW = MAX_BURST_BEATS * BYTES;
    // Anything above 8 KB can never win against the 4 KB limit, so cap it to stay in CW bits.
    localparam int MAXB_CAP = (MAXB_RAW > 8192) ? 8192 : MAXB_RAW;

    logic [CW-1:0] w_off, w_to4k, w_maxb, w_rem, w_min, w_bytes;

    assign w_off   = CW'(addr_lo_i) & CW'(BYTES - 1);
    assign w_to4k  = CW'(AXI_4K) - CW'(addr_lo_i);
    assign w_maxb  = CW'(MAXB_CAP) - w_off;
    assign w_rem   = CW'(remaining_i);
    assign w_min   = (w_to4k < w_maxb) ? w_to4k : w_maxb;
    assign w_bytes = (w_rem < w_min) ? w_rem : w_min;

    // bytes >= 1 here, so floor((off+bytes-1)/BYTES) equals ceil((off+bytes)/BYTES)-1.
    assign beats_m1_o = 8'((w_off + w_bytes - CW'(1)) >> SHIFT);
    assign bytes_o    = 13'(w_bytes);
    assign off_o      = OFFSET_W'(w_off);
    assign last_o     = (w_bytes == w_rem);

endmodule

// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - splits a byte transfer into 4 KB-safe AXI INCR address bursts
module axi_burst_splitter
    import axi_burst_splitter_pkg::*;
#(
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_DATA_W      = 32,
    parameter int LEN_W           = 20,
    parameter int MAX_BURST_BEATS = 256,
    localparam int OFFSET_W = (calculate_AXI_OFFSET_W(AXI_DATA_W) < 1) ? 1
                              : calculate_AXI_OFFSET_W(AXI_DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [AXI_ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    output logic [AXI_ADDR_W-1:0] m_axi_axaddr_o,
    output logic [7:0]            m_axi_axlen_o,
    output logic [2:0]            m_axi_axsize_o,
    output logic [1:0]            m_axi_axburst_o,
    output logic                  m_axi_axvalid_o,
    input  logic                  m_axi_axready_i,
    output logic [12:0]           burst_bytes_o,
    output logic [OFFSET_W-1:0]   burst_offset_o,
    output logic                  burst_first_o,
    output logic                  burst_last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int                    BYTES     = AXI_DATA_W / 8;
    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = AXI_ADDR_W'(BYTES - 1);

    state_t                r_state;
    logic [AXI_ADDR_W-1:0] r_addr, r_axaddr;
    logic [LEN_W-1:0]      r_rem;
    logic [7:0]            r_axlen;
    logic [12:0]           r_bytes;
    logic [OFFSET_W-1:0]   r_offset;
    logic                  r_first, r_last, r_axvalid, r_done;

    logic [12:0]           w_bytes;
    logic [7:0]            w_beats_m1;
    logic [OFFSET_W-1:0]   w_off;
    logic                  w_last;

    axi_burst_calc #(
        .AXI_DATA_W      (AXI_DATA_W),
        .LEN_W           (LEN_W),
        .MAX_BURST_BEATS (MAX_BURST_BEATS),
        .OFFSET_W        (OFFSET_W)
    ) u_calc (
        .addr_lo_i   (r_addr[11:0]),
        .remaining_i (r_rem),
        .bytes_o     (w_bytes),
        .beats_m1_o  (w_beats_m1),
        .off_o       (w_off),
        .last_o      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_axaddr  <= '0;
            r_axlen   <= '0;
            r_bytes   <= '0;
            r_offset  <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_axvalid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_len_i != '0) begin
                            r_addr  <= cmd_addr_i;
                            r_rem   <= cmd_len_i;
                            r_first <= 1'b1;
                            r_state <= ST_CALC;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_axaddr  <= r_addr & ~ADDR_MASK;
                    r_axlen   <= w_beats_m1;
                    r_bytes   <= w_bytes;
                    r_offset  <= w_off;
                    r_last    <= w_last;
                    r_axvalid <= 1'b1;
                    r_state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (m_axi_axready_i) begin
                        r_addr    <= r_addr + AXI_ADDR_W'(r_bytes);
                        r_rem     <= r_rem - LEN_W'(r_bytes);
                        r_first   <= 1'b0;
                        r_axvalid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o     = (r_state == ST_IDLE);
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;
    assign m_axi_axaddr_o  = r_axaddr;
    assign m_axi_axlen_o   = r_axlen;
    assign m_axi_axsize_o  = calculate_AXI_AXSIZE(AXI_DATA_W);
    assign m_axi_axburst_o = AXI_BURST_INCR;
    assign m_axi_axvalid_o = r_axvalid;
    assign burst_bytes_o   = r_bytes;
    assign burst_offset_o  = r_offset;
    assign burst_first_o   = r_first;
    assign burst_last_o    = r_last;

endmodule

// File: tb/tb_axi_burst_splitter.sv
// tb/tb_axi_burst_splitter.sv - self-checking bench with a burst-list model and scoreboard
module tb_axi_burst_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [19:0] cmd_len = '0;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
    logic        axvalid;
    logic        axready = 1'b1;
    logic [12:0] bbytes;
    logic [1:0]  boffset;
    logic        bfirst, blast, busy, done;

    always #5 clk = ~clk;

    axi_burst_splitter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_addr_i      (cmd_addr),
        .cmd_len_i       (cmd_len),
        .m_axi_axaddr_o  (axaddr),
        .m_axi_axlen_o   (axlen),
        .m_axi_axsize_o  (axsize),
        .m_axi_axburst_o (axburst),
        .m_axi_axvalid_o (axvalid),
        .m_axi_axready_i (axready),
        .burst_bytes_o   (bbytes),
        .burst_offset_o  (boffset),
        .burst_first_o   (bfirst),
        .burst_last_o    (blast),
        .busy_o          (busy),
        .done_o          (done)
    );

    typedef struct {
        longint addr;
        int     len;
        int     bytes;
        int     off;
        bit     first;
        bit     last;
    } burst_t;

    burst_t exp_q[$];
    burst_t cap[$];
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Burst list straight from the splitting rules: 4 KB limit, 1 KB per burst (256 x 4 bytes).
    function automatic void model_cmd(input longint addr, input int len);
        longint a;
        int     rem;
        bit     first;
        int     off, to4k, maxb, b;
        burst_t t;
        a = addr;
        rem = len;
        first = 1'b1;
        while (rem > 0) begin
            off  = int'(a % 4);
            to4k = 4096 - int'(a % 4096);
            maxb = 1024 - off;
            b = rem;
            if (to4k < b) b = to4k;
            if (maxb < b) b = maxb;
            t.addr  = a - off;
            t.len   = (off + b + 3) / 4 - 1;
            t.bytes = b;
            t.off   = off;
            t.first = first;
            t.last  = (b == rem);
            exp_q.push_back(t);
            a = (a + b) % 64'h1_0000_0000;
            rem = rem - b;
            first = 1'b0;
        end
    endfunction

    bit     pend = 1'b0;
    bit     exp_done = 1'b0;
    burst_t p, cur, e;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            exp_done = 1'b0;
        end else begin
            chk("done_o", done, exp_done);
            exp_done = 1'b0;
            if (cmd_valid && cmd_ready && cmd_len == 0) exp_done = 1'b1;
            cur.addr = axaddr;
            cur.len = axlen;
            cur.bytes = bbytes;
            cur.off = boffset;
            cur.first = bfirst;
            cur.last = blast;
            if (pend) begin
                chk("hold_valid", axvalid, 1);
                chk("hold_addr", cur.addr, p.addr);
                chk("hold_len", cur.len, p.len);
                chk("hold_bytes", cur.bytes, p.bytes);
                chk("hold_off", cur.off, p.off);
                chk("hold_first", cur.first, p.first);
                chk("hold_last", cur.last, p.last);
            end
            if (axvalid) begin
                chk("axsize", axsize, 2);
                chk("axburst", axburst, 1);
                chk("no_4k_cross", ((cur.addr % 4096) + (cur.len + 1) * 4) <= 4096, 1);
                chk("later_aligned", (!cur.first && cur.off != 0), 0);
                if (axready) begin
                    pend = 1'b0;
                    cap.push_back(cur);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_burst: got burst at 0x%0h expected none", cur.addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_addr", cur.addr, e.addr);
                        chk("sb_len", cur.len, e.len);
                        chk("sb_bytes", cur.bytes, e.bytes);
                        chk("sb_off", cur.off, e.off);
                        chk("sb_first", cur.first, e.first);
                        chk("sb_last", cur.last, e.last);
                    end
                    if (cur.last) exp_done = 1'b1;
                end else begin
                    pend = 1'b1;
                    p = cur;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic send(input longint addr, input int len);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("cmd_ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr = addr[31:0];
        cmd_len = 20'(len);
        model_cmd(addr, len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, (len != 0));
        if (len == 0) begin
            chk("zero_len_done", done, 1);
            chk("zero_len_novalid", axvalid, 0);
        end else begin
            chk("valid_at_n1", axvalid, 0);
            @(posedge clk); #1;
            chk("valid_at_n2", axvalid, 1);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_within_budget", (t < 3000), 1);
        chk("idle_at_done", busy, 0);
    endtask

    task automatic cap_chk(input int i, input longint addr, input int len, input int bytes,
                           input int off, input bit first, input bit last);
        if (i >= cap.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL cap_missing: got %0d bursts expected index %0d", cap.size(), i);
        end else begin
            chk("lit_addr", cap[i].addr, addr);
            chk("lit_len", cap[i].len, len);
            chk("lit_bytes", cap[i].bytes, bytes);
            chk("lit_off", cap[i].off, off);
            chk("lit_first", cap[i].first, first);
            chk("lit_last", cap[i].last, last);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_axvalid", axvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_axlen", axlen, 0);
        chk("rst_axsize", axsize, 2);
        chk("rst_axburst", axburst, 1);
        rst_n = 1'b1;

        cap.delete();
        send(32'h1000, 16);
        wait_done();
        chk("t1_count", cap.size(), 1);
        cap_chk(0, 32'h1000, 3, 16, 0, 1, 1);

        cap.delete();
        send(32'h0FFE, 8);
        wait_done();
        chk("t2_count", cap.size(), 2);
        cap_chk(0, 32'h0FFC, 0, 2, 2, 1, 0);
        cap_chk(1, 32'h1000, 1, 6, 0, 0, 1);

        cap.delete();
        send(32'h2000, 2048);
        wait_done();
        chk("t3_count", cap.size(), 2);
        cap_chk(0, 32'h2000, 255, 1024, 0, 1, 0);
        cap_chk(1, 32'h2400, 255, 1024, 0, 0, 1);

        cap.delete();
        send(32'h0003, 2000);
        wait_done();
        chk("t4_count", cap.size(), 2);
        cap_chk(0, 32'h0000, 255, 1021, 3, 1, 0);
        cap_chk(1, 32'h0400, 244, 979, 0, 0, 1);

        cap.delete();
        send(32'h0500, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_busy", busy, 0);
            chk("t5_axvalid", axvalid, 0);
        end
        chk("t5_count", cap.size(), 0);

        cap.delete();
        axready = 1'b0;
        send(32'h0FFE, 8);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_valid_held", axvalid, 1);
        chk("bp_no_handshake", cap.size(), 0);
        axready = 1'b1;
        wait_done();
        chk("bp_count", cap.size(), 2);
        cap_chk(0, 32'h0FFC, 0, 2, 2, 1, 0);

        send(32'h3000, 64);
        axready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_axvalid", axvalid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        axready = 1'b1;
        cap.delete();
        send(32'h1000, 16);
        wait_done();
        chk("post_rst_count", cap.size(), 1);
        cap_chk(0, 32'h1000, 3, 16, 0, 1, 1);

        repeat (3) @(posedge clk);
        chk("model_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
